diff_iter_unit: RTL and testbench
=================================

Name: diff_iter_unit

Overview:
- Parametrised, multi-cycle successor to the combinational 32-bit DIFF datapath in the miniRISC ALU.
- Computes the `diff` result: the bit position of the least-significant bit where operands a and b differ, plus a flag for the equal-operand case.
- Scans a^b in STEP-bit chunks, one chunk per clock, under a start/busy/done handshake.
- Sits beside the ALU; the control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width; must be a multiple of STEP.
- STEP, 4, bits examined per cycle; must be a power of two, 1..WIDTH.
- POS_W, $clog2(WIDTH), width of pos output; derived, do not override.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when the unit is ready (IDLE or DONE state).
- a  in  WIDTH  operand A; sampled on the edge that accepts start.
- b  in  WIDTH  operand B; sampled on the edge that accepts start.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse; pos and no_diff are valid.
- pos  out  POS_W  index of the lowest differing bit.
- no_diff  out  1  high when a==b; pos is 0 in that case.

Behaviour:
- Reset (asynchronous, rst_n low, any state, including mid-scan):
  - state=IDLE; busy=0, done=0, pos=0, no_diff=0.
  - Internal x register and chunk counter cleared; any in-flight operation is discarded.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge E0: latch x=a^b, chunk=0, clear found flag, go to SCAN.
  - start=0: stay in IDLE.
- SCAN, one chunk per cycle:
  - Evaluate slice x[chunk*STEP +: STEP].
  - If the slice is nonzero and no earlier chunk was found: record pos = chunk*STEP + lowest set offset, and set found.
  - Terminate and go to DONE in either case:
    - a hit (early exit), or
    - chunk = WIDTH/STEP-1.
  - Otherwise increment chunk.
  - At termination with nothing found: no_diff=1, pos=0.
- DONE:
  - done=1 for exactly one cycle.
  - pos and no_diff are registered and held until the next accepted start.
  - start=1 here is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- Latency: first hit in chunk k → done high in the cycle after edge E(k+1), i.e. k+1 cycles. Maximum latency is WIDTH/STEP cycles.
- start while busy is ignored; operands are not resampled.
- pos and no_diff update only on DONE entry.
- a/b changes after the accepting edge have no effect.
- WIDTH==STEP is legal: single-cycle scan, latency 1.

Optional Feature:
- Macro: DIFF_ITER_EARLY_EXIT_EN.
- Defined: terminate on first nonzero chunk; latency k+1, as described under Behaviour.
- Undefined: always scan all WIDTH/STEP chunks; fixed latency WIDTH/STEP for deterministic stall timing. Only the first hit is recorded.
- pos and no_diff results are identical in both modes.

Decomposition:
- Package diff_iter_pkg holds:
  - the state enum type (IDLE/SCAN/DONE) and its encoding;
  - the function computing NCHUNK=WIDTH/STEP;
  - the chunk-counter width $clog2(NCHUNK).
- Sub-module diff_prio_enc: combinational STEP-bit lowest-set-bit encoder.
  - Outputs: offset[$clog2(STEP)-1:0] and any.
  - For STEP=1: offset is 0 and any = the input bit.

Test Plan (WIDTH=32, STEP=4, early exit enabled unless noted):
- a=0x0000000F, b=0x00000001 → pos=1, no_diff=0, done 1 cycle after accept.
- a=0x00000010, b=0 → pos=4, done 2 cycles after accept. With the macro undefined: same pos, done at 8 cycles.
- a=0x80000000, b=0 → pos=31, done at 8 cycles, busy high for 8 cycles.
- a=b=0xDEADBEEF → no_diff=1, pos=0, done at 8 cycles.
- Start accepted with a=0x100, b=0:
  - pulse start again with new operands during busy → ignored, result pos=8;
  - start held high in DONE → second op accepted immediately, no idle gap.
- rst_n low for 1 cycle during chunk 3 of a=0x80000000, b=0 → all outputs 0, state IDLE, no done pulse; next op a=0x2, b=0 → pos=1.

Source files
------------

// File: rtl/diff_iter_pkg.sv
// Shared types and helpers for the iterative diff unit.
// Optional early termination: DIFF_ITER_EARLY_EXIT_EN.
package diff_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int step);
    return width / step;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/diff_prio_enc.sv
// Lowest-set-bit encoder for one STEP-bit chunk.
// offset is 0 when no bit is set.
module diff_prio_enc #(
  parameter int STEP = 4,
  parameter int OW   = (STEP > 1) ? $clog2(STEP) : 1
) (
  input  logic [STEP-1:0] in,
  output logic [OW-1:0]   offset,
  output logic            any
);

  // scan from the top so the lowest set bit wins
  always_comb begin
    offset = '0;
    any    = |in;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (in[i]) offset = OW'(i);
    end
  end

endmodule

// File: rtl/diff_iter_unit.sv
// Multi-cycle lowest-differing-bit finder, STEP bits per clock.
// Optional early termination: DIFF_ITER_EARLY_EXIT_EN.
module diff_iter_unit
  import diff_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] pos,
  output logic             no_diff
);

  localparam int NCHUNK = nchunk(WIDTH, STEP);
  localparam int CW     = cnt_w(NCHUNK);
  localparam int OW     = (STEP > 1) ? $clog2(STEP) : 1;

  state_t           state, nxt;
  logic [WIDTH-1:0] x;
  logic [CW-1:0]    chunk;
  logic             found;
  logic [POS_W-1:0] hit_pos;
  logic [POS_W-1:0] pos_q;
  logic             nd_q;

  logic [STEP-1:0]  slice;
  logic [OW-1:0]    off;
  logic             any;
  logic             last;
  logic             term;
  logic             accept;
  logic [POS_W-1:0] cur_pos;
  logic [POS_W-1:0] res_pos;
  logic             res_found;

  diff_prio_enc #(
    .STEP (STEP),
    .OW   (OW)
  ) u_enc (
    .in     (slice),
    .offset (off),
    .any    (any)
  );

  // chunk selection, termination and result merge
  always_comb begin
    slice   = x[chunk*STEP +: STEP];
    last    = (chunk == CW'(NCHUNK - 1));
`ifdef DIFF_ITER_EARLY_EXIT_EN
    term    = last | any;
`else
    term    = last;
`endif
    accept  = start && (state == IDLE || state == DONE);
    cur_pos = POS_W'(chunk) * POS_W'(STEP) + POS_W'(off);
    res_found = found | any;
    res_pos   = '0;
    if (found)    res_pos = hit_pos;
    else if (any) res_pos = cur_pos;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = SCAN;
      SCAN:    if (term)  nxt = DONE;
      DONE:    nxt = start ? SCAN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // operand latch, chunk walk and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      chunk   <= '0;
      found   <= 1'b0;
      hit_pos <= '0;
      pos_q   <= '0;
      nd_q    <= 1'b0;
    end else if (accept) begin
      x       <= a ^ b;
      chunk   <= '0;
      found   <= 1'b0;
      hit_pos <= '0;
    end else if (state == SCAN) begin
      if (any && !found) begin
        found   <= 1'b1;
        hit_pos <= cur_pos;
      end
      if (term) begin
        pos_q <= res_pos;
        nd_q  <= !res_found;
      end else begin
        chunk <= chunk + CW'(1);
      end
    end
  end

  assign busy    = (state == SCAN);
  assign done    = (state == DONE);
  assign pos     = pos_q;
  assign no_diff = nd_q;

endmodule

// File: tb/tb_diff_iter_unit.sv
// Directed bench for diff_iter_unit (WIDTH=32, STEP=4).
// Expected latency follows DIFF_ITER_EARLY_EXIT_EN.
module tb_diff_iter_unit;

`ifdef DIFF_ITER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy;
  logic        done;
  logic [4:0]  pos;
  logic        no_diff;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  diff_iter_unit #(
    .WIDTH (32),
    .STEP  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .pos     (pos),
    .no_diff (no_diff)
  );

  function automatic int exp_lat(input int k);
    return EE ? k + 1 : 8;
  endfunction

  // wait for done after an accepting edge; bounded
  task automatic wait_done(output int lat, output int bcnt);
    bit seen;
    seen = 0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1;
      else if (busy) bcnt++;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt,
                       output logic [4:0] p, output logic nd);
    @(negedge clk);
    a_i = a; b_i = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_i = $urandom; b_i = $urandom;
    wait_done(lat, bcnt);
    p  = pos;
    nd = no_diff;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, pos, no_diff} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b pos=%0d nd=%b want all 0",
               busy, done, pos, no_diff);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_vectors;
    logic [31:0] va [5];
    logic [31:0] vb [5];
    int          vp [5];
    int          vn [5];
    int          vk [5];
    int          lat, bcnt;
    logic [4:0]  p;
    logic        nd;
    va = '{32'h0000000F, 32'h00000010, 32'h80000000, 32'hDEADBEEF, 32'h00300000};
    vb = '{32'h00000001, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 32'h00100000};
    vp = '{1, 4, 31, 0, 21};
    vn = '{0, 0, 0, 1, 0};
    vk = '{0, 1, 7, 7, 5};
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], lat, bcnt, p, nd);
      checks++;
      if (p !== vp[i][4:0]) begin
        errors++;
        $display("FAIL vec%0d_pos got %0d want %0d", i, p, vp[i]);
      end
      checks++;
      if (nd !== vn[i][0]) begin
        errors++;
        $display("FAIL vec%0d_no_diff got %b want %0d", i, nd, vn[i]);
      end
      checks++;
      if (lat != exp_lat(vk[i])) begin
        errors++;
        $display("FAIL vec%0d_latency got %0d want %0d", i, lat, exp_lat(vk[i]));
      end
      checks++;
      if (bcnt != exp_lat(vk[i])) begin
        errors++;
        $display("FAIL vec%0d_busy_cycles got %0d want %0d", i, bcnt, exp_lat(vk[i]));
      end
    end
  endtask

  task automatic test_hold;
    int         lat, bcnt;
    logic [4:0] p;
    logic       nd;
    do_op(32'h00000040, 32'h0, lat, bcnt, p, nd);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL hold_done_pulse got %b want 0", done);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pos !== 5'd6 || no_diff !== 1'b0) begin
      errors++;
      $display("FAIL hold_result got pos=%0d nd=%b want 6 0", pos, no_diff);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bcnt;
    @(negedge clk);
    a_i = 32'h100; b_i = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a_i = 32'h1; b_i = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_i = 32'h0; b_i = 32'h0;
    wait_done(lat, bcnt);
    lat++;
    checks++;
    if (pos !== 5'd8 || no_diff !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_pos got %0d nd=%b want 8 0", pos, no_diff);
    end
    checks++;
    if (lat != exp_lat(2)) begin
      errors++;
      $display("FAIL ignore_start_latency got %0d want %0d", lat, exp_lat(2));
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    @(negedge clk);
    a_i = 32'h10; b_i = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat, bcnt);
    checks++;
    if (pos !== 5'd4 || lat != exp_lat(1)) begin
      errors++;
      $display("FAIL b2b_first got pos=%0d lat=%0d want 4 %0d", pos, lat, exp_lat(1));
    end
    a_i = 32'h8000; b_i = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_gap got busy=%b want 1", busy);
    end
    start = 1'b0;
    a_i = 32'hFFFF_FFFF;
    wait_done(lat, bcnt);
    checks++;
    if (pos !== 5'd15 || no_diff !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_pos got %0d nd=%b want 15 0", pos, no_diff);
    end
    checks++;
    if (lat != exp_lat(3)) begin
      errors++;
      $display("FAIL b2b_second_latency got %0d want %0d", lat, exp_lat(3));
    end
  endtask

  task automatic test_mid_reset;
    int         dcnt, lat, bcnt;
    logic [4:0] p;
    logic       nd;
    @(negedge clk);
    a_i = 32'h80000000; b_i = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pos, no_diff} !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_outputs got busy=%b done=%b pos=%0d nd=%b want all 0",
               busy, done, pos, no_diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet got %0d active cycles want 0", dcnt);
    end
    do_op(32'h2, 32'h0, lat, bcnt, p, nd);
    checks++;
    if (p !== 5'd1 || nd !== 1'b0 || lat != exp_lat(0)) begin
      errors++;
      $display("FAIL mid_reset_next_op got pos=%0d nd=%b lat=%0d want 1 0 %0d",
               p, nd, lat, exp_lat(0));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
